// File: rtl/cook_timer_seq.sv
// Microwave cook-timer sequencer: keypad m:ss BCD entry, 1 s countdown while run is high, timer_done at 0:00.
// Optional macro ADD30_EN enables key 4'hA as a saturating +30 s key.
module cook_timer_seq #(
  parameter int PRESCALE = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_data,
  input  logic       keypad_valid,
  input  logic       clearn,
  input  logic       run,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       timer_done
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, ENTRY, COUNT, PAUSE, DONE} state_t;
  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
  } bcd_t;

  state_t        state;
  bcd_t          cur;
  logic [PW-1:0] pre;

  logic tick, key_dig, key_add;
  bcd_t t_dec, t_new;

  // Never goes below 0:00; borrow chain runs ones -> tens -> minutes.
  function automatic bcd_t dec_1s(input bcd_t v);
    bcd_t r;
    r = v;
    if (v != '0) begin
      if (v.o != 4'd0) r.o = v.o - 4'd1;
      else begin
        r.o = 4'd9;
        if (v.t != 4'd0) r.t = v.t - 4'd1;
        else begin
          r.t = 4'd5;
          r.m = v.m - 4'd1;
        end
      end
    end
    return r;
  endfunction

`ifdef ADD30_EN
  function automatic bcd_t add_30s(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.t >= 4'd3) begin
      if (v.m == 4'd9) r = '{m: 4'd9, t: 4'd5, o: 4'd9};
      else begin
        r.t = v.t - 4'd3;
        r.m = v.m + 4'd1;
      end
    end else r.t = v.t + 4'd3;
    return r;
  endfunction

  assign key_add = keypad_valid && (keypad_data == 4'hA) && (state != DONE);
`else
  assign key_add = 1'b0;
`endif

  // A digit is refused when it would push an invalid (>5) value into the tens place.
  assign key_dig = keypad_valid && (keypad_data <= 4'd9) && (cur.o <= 4'd5);
  assign tick    = (state == COUNT) && run && (pre == PMAX);

  always_comb begin
    t_dec = tick ? dec_1s(cur) : cur;
    t_new = t_dec;
`ifdef ADD30_EN
    if (key_add) t_new = add_30s(t_dec);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      pre        <= '0;
      timer_done <= 1'b0;
    end else if (!clearn) begin
      state      <= IDLE;
      cur        <= '0;
      pre        <= '0;
      timer_done <= 1'b0;
    end else begin
      case (state)
        IDLE, ENTRY, DONE: begin
          if (state == ENTRY && run && !zero) begin
            state <= COUNT;
            pre   <= '0;
            cur   <= t_new;
          end else if (!run && key_dig) begin
            cur        <= {cur.t, cur.o, keypad_data};
            state      <= ENTRY;
            timer_done <= 1'b0;
          end else if (key_add) begin
            cur   <= t_new;
            state <= ENTRY;
          end
        end
        COUNT: begin
          cur <= t_new;
          if (!run) state <= PAUSE;
          else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (t_new == '0) begin
              state      <= DONE;
              timer_done <= 1'b1;
            end
          end
        end
        PAUSE: begin
          cur <= t_new;
          if (run) state <= COUNT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign min_ones = cur.m;
  assign sec_tens = cur.t;
  assign sec_ones = cur.o;
  assign zero     = (cur == '0);
endmodule
